// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared constants and FSM state encoding for the data-memory initiator
package mem_access_unit_pkg;

   localparam int DATA_W     = 64;
   localparam int DMEM_DEPTH = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD      = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR      = 3'd3,
      ST_RESP    = 3'd4
   } state_t;

endpackage

// File: rtl/mem_access_unit_sat_counter.sv
// rtl/mem_access_unit_sat_counter.sv - saturating event counter
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // count up on inc, sticking at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for the 64-bit data memory
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int WORD  = DATA_W,
   parameter int DEPTH = DMEM_DEPTH,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [WORD-1:0]  req_addr,
   input  logic [WORD-1:0]  req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WORD-1:0]  rsp_rdata,
   output logic             rsp_err,
   output logic             mem_read,
   output logic             mem_write,
   output logic [WORD-1:0]  mem_addr,
   output logic [WORD-1:0]  mem_wdata,
   input  logic [WORD-1:0]  mem_rdata,
   output logic [CNT_W-1:0] n_loads,
   output logic [CNT_W-1:0] n_stores
);

   state_t            state, state_n;
   logic              mem_read_n, mem_write_n;
   logic [WORD-1:0]   mem_addr_n, mem_wdata_n;
   logic              rsp_valid_n, rsp_err_n;
   logic [WORD-1:0]   rsp_rdata_n;
   logic              load_inc, store_inc;
   logic              req_bad;

   // misaligned or beyond the last word: rejected without touching memory
   assign req_bad   = (req_addr[2:0] != 3'b000) || ((req_addr >> 3) >= WORD'(DEPTH));
   assign req_ready = (state == ST_IDLE);

   // next state and next values of every registered output;
   // mem_addr/mem_wdata double as the latched request registers
   always_comb begin
      state_n     = state;
      mem_read_n  = 1'b0;
      mem_write_n = 1'b0;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      rsp_valid_n = rsp_valid;
      rsp_err_n   = rsp_err;
      rsp_rdata_n = rsp_rdata;
      load_inc    = 1'b0;
      store_inc   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_bad) begin
                  rsp_err_n   = 1'b1;
                  rsp_rdata_n = '0;
                  rsp_valid_n = 1'b1;
                  state_n     = ST_RESP;
               end else if (req_write) begin
                  mem_write_n = 1'b1;
                  mem_addr_n  = req_addr;
                  mem_wdata_n = req_wdata;
                  state_n     = ST_WR;
               end else begin
                  mem_read_n  = 1'b1;
                  mem_addr_n  = req_addr;
                  state_n     = ST_RD;
               end
            end
         end
         ST_RD: begin
            // keep MemRead up through RD_WAIT so the memory drives data, not Z
            mem_read_n = 1'b1;
            state_n    = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            rsp_rdata_n = mem_rdata;
            rsp_valid_n = 1'b1;
            load_inc    = 1'b1;
            state_n     = ST_RESP;
         end
         ST_WR: begin
            rsp_rdata_n = '0;
            rsp_valid_n = 1'b1;
            store_inc   = 1'b1;
            state_n     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_n = 1'b0;
               rsp_err_n   = 1'b0;
               state_n     = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // state and registered outputs; reset drops any strobe and discards the response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state     <= state_n;
         mem_read  <= mem_read_n;
         mem_write <= mem_write_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         rsp_valid <= rsp_valid_n;
         rsp_err   <= rsp_err_n;
         rsp_rdata <= rsp_rdata_n;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (load_inc),
      .count (n_loads)
   );

   sat_counter #(.CNT_W(CNT_W)) u_store_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (store_inc),
      .count (n_stores)
   );

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side controller for the 64-bit data memory: accepts load/store requests from the datapath over a valid/ready handshake and drives the memory's MemRead/MemWrite/address/write_data strobes. It checks alignment and range, captures read data at the correct cycle, and returns a response with an error flag. It counts completed loads and stores. It sits between the execute/memory stage and the data memory; both memory clocks are tied to `clk` at the top level.

## Interface
- `WORD`, 64: data and address width (`` `WORD ``)
- `DEPTH`, 32: memory depth in words; valid byte addresses are 0 to DEPTH*8-8
- `CNT_W`, 32: width of the access counters
- `clk`  in  1: single clock; all state updates on posedge
- `rst_n`  in  1: asynchronous, active-low reset
- `req_valid`  in  1: request present
- `req_ready`  out  1: unit can accept a request (high only in IDLE)
- `req_write`  in  1: 1 = store (STUR), 0 = load (LDUR)
- `req_addr`  in  WORD: byte address
- `req_wdata`  in  WORD: store data
- `rsp_valid`  out  1: response present
- `rsp_ready`  in  1: consumer accepts response
- `rsp_rdata`  out  WORD: load data (0 for stores and errors)
- `rsp_err`  out  1: misaligned or out-of-range request; no memory access made
- `mem_read`  out  1: to memory MemRead
- `mem_write`  out  1: to memory MemWrite
- `mem_addr`  out  WORD: byte address to memory (memory divides by 8)
- `mem_wdata`  out  WORD: store data to memory
- `mem_rdata`  in  WORD: memory read_data; registered in memory, Z when not reading
- `n_loads`, `n_stores`  out  CNT_W: completed, error-free accesses; saturating

## Operation
- FSM states: IDLE, RD, RD_WAIT, WR, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch addr, wdata and write into request registers.
  - If `req_addr[2:0]`≠0 or `req_addr>>3` ≥ DEPTH: set `rsp_err`=1, `rsp_rdata`=0, go to RESP.
  - Otherwise go to WR if `req_write`=1, else to RD.
- **RD**
  - `mem_read`=1, `mem_addr`=latched address; the memory samples at the end of this cycle.
  - Go to RD_WAIT.
- **RD_WAIT**
  - `mem_read` remains 1 so the memory does not drive Z.
  - `mem_rdata` is captured into `rsp_rdata` at the end of this cycle.
  - Increment `n_loads`; go to RESP.
- **WR**
  - `mem_write`=1, `mem_addr`, and `mem_wdata`=latched data for exactly one cycle.
  - Increment `n_stores`; `rsp_rdata`=0; go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_rdata` and `rsp_err` are held stable.
  - When `rsp_ready`=1, go to IDLE; `rsp_err` clears on leaving.
- All `mem_*` outputs and `rsp_*` outputs are registered. `mem_read` and `mem_write` are never both 1.
- `mem_addr` and `mem_wdata` hold their last value when idle; the memory ignores them without a strobe.
- Counters saturate at all-ones and never wrap. Error requests increment neither counter.

## Timing
- Reset values (asynchronous, on `rst_n`=0):
  - FSM=IDLE.
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
  - Counters=0.
- Latency, counted from the accepting edge (edge 0):
  - Load: `mem_read` high in cycles 1–2; `rsp_valid` high from cycle 3.
  - Store: `mem_write` high in cycle 1; `rsp_valid` high from cycle 2.
  - Error: `rsp_valid` high from cycle 1.
- Throughput with `rsp_ready` tied to 1: one load per 4 cycles, one store per 3 cycles, one error per 2 cycles.
- `req_valid` is ignored while `req_ready`=0. The requester must hold the request until the handshake completes.
- `rsp_ready` low stalls in RESP indefinitely with no further memory activity.
- Reset mid-operation:
  - Any strobe deasserts immediately and the response is discarded.
  - A write whose `mem_write` edge has already occurred stays committed.

## Structure
- Constants `` `WORD `` and `` `DMEM_DEPTH `` and the FSM state encodings (3-bit localparams) go in `definitions.vh`.
- One sub-module, `sat_counter`, instantiated twice:
  - Parameter `CNT_W`.
  - Ports `clk`, `rst_n`, `inc`, `count`.
- Top-level wiring ties the memory's `read_clk` and `write_clk` to `clk`.

## Test plan
- Store 0xDEADBEEF_0000_0001 to address 0x10, then load 0x10 → `mem_write` pulses one cycle at addr 0x10; load returns the same value with `rsp_err`=0 at cycle 3; `n_stores`=1, `n_loads`=1.
- Load 0x0C (misaligned) and load 0x100 (word 32 with DEPTH=32) → each gives `rsp_err`=1 and `rsp_rdata`=0 at cycle 1; no `mem_read` or `mem_write` asserted; counters unchanged.
- Load with `rsp_ready` held low 5 cycles → `rsp_valid` and `rsp_rdata` stable for 5 cycles; `req_ready`=0 throughout; a `req_valid` pulse during the stall is not accepted.
- Back-to-back: 4 loads with `rsp_ready`=1 → `rsp_valid` at cycles 3, 7, 11, 15; never simultaneous `mem_read`/`mem_write`.
- `rst_n` low during a load's RD_WAIT cycle → `mem_read`=0 and `rsp_valid`=0 immediately; after release, IDLE with `req_ready`=1 and `n_loads`=0.
- Force counters to 0xFFFF_FFFE, then perform 3 stores → `n_stores` reads 0xFFFF_FFFF and holds.
